// File: rtl/arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arbiter_pkg
// Shared types and helpers for the physical-memory arbiter (mem_arbiter_n)
// and its request picker (arb_picker).
//   arb_state_t : transaction FSM states (IDLE, BUSY, DONE)
//   arb_op_t    : latched memory operation (OP_READ, OP_WRITE)
//   grant_w()   : width of a channel index for a given channel count
// ---------------------------------------------------------------------------
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

    // Width of a grant index; never below one bit so a 1-bit vector is legal.
    function automatic int grant_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// ---------------------------------------------------------------------------
// arb_picker
// Combinational winner selection among NUM_CH pending requesters.
// The search starts at rr_ptr and wraps from NUM_CH-1 back to 0; the first
// pending channel found wins. Feeding rr_ptr a constant zero turns this into
// a fixed lowest-index-wins priority picker.
// Ports:
//   pending   in  NUM_CH   per-channel request pending
//   rr_ptr    in  GRANT_W  channel index where the search starts
//   grant     out GRANT_W  winning channel index (0 when nothing pending)
//   any_valid out 1        at least one channel pending
// ---------------------------------------------------------------------------
module arb_picker
    import arbiter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int GRANT_W = grant_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0]  pending,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic [GRANT_W-1:0] grant,
    output logic               any_valid
);

    int idx_s;

    // Rotating scan from the highest offset down so the lowest offset from
    // rr_ptr is the last (and therefore winning) assignment.
    always_comb begin
        grant     = {GRANT_W{1'b0}};
        idx_s     = 0;
        any_valid = |pending;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx_s = int'(rr_ptr) + k;
            if (idx_s >= NUM_CH) begin
                idx_s = idx_s - NUM_CH;
            end else begin
                idx_s = idx_s;
            end
            if (pending[idx_s[GRANT_W-1:0]]) begin
                grant = idx_s[GRANT_W-1:0];
            end else begin
                grant = grant;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// ---------------------------------------------------------------------------
// mem_arbiter_n
// Arbitrates NUM_CH cache-side requesters (ch0 = I-cache, ch1 = D-cache,
// further channels for prefetch/victim buffers) onto one physical-memory
// port. The winning request is latched and held on pmem_* until pmem_resp;
// the completion and read data are routed back to the granted channel only.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined     : round-robin, search starts at rr_ptr, rr_ptr <= grant+1
//   not defined : fixed priority, lowest channel index wins
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   ch_read      per-channel read request (held until ch_resp)
//   ch_write     per-channel write request (held until ch_resp)
//   ch_addr      per-channel line address
//   ch_wdata     per-channel write line
//   ch_resp      one-hot 1-cycle completion to the granted channel
//   ch_rdata     read line (pass-through of pmem_rdata)
//   pmem_read    registered read strobe
//   pmem_write   registered write strobe
//   pmem_addr    registered address of the granted request
//   pmem_wdata   registered write line of the granted request
//   pmem_rdata   memory read data
//   pmem_resp    memory completion pulse
// ---------------------------------------------------------------------------
module mem_arbiter_n
    import arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_read,
    input  logic [NUM_CH-1:0]              ch_write,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
    input  logic [NUM_CH-1:0][LINE_W-1:0]  ch_wdata,
    output logic [NUM_CH-1:0]              ch_resp,
    output logic [LINE_W-1:0]              ch_rdata,
    output logic                           pmem_read,
    output logic                           pmem_write,
    output logic [ADDR_W-1:0]              pmem_addr,
    output logic [LINE_W-1:0]              pmem_wdata,
    input  logic [LINE_W-1:0]              pmem_rdata,
    input  logic                           pmem_resp
);

    localparam int GRANT_W = grant_w(NUM_CH);

    arb_state_t         state_r;
    arb_state_t         state_nxt_s;
    logic [GRANT_W-1:0] grant_r;
    logic [GRANT_W-1:0] pick_s;
    logic [GRANT_W-1:0] rr_ptr_s;
    logic               any_valid_s;
    logic [NUM_CH-1:0]  pending_s;
    arb_op_t            win_op_s;

    assign pending_s = ch_read | ch_write;

    arb_picker #(
        .NUM_CH  (NUM_CH),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .pending   (pending_s),
        .rr_ptr    (rr_ptr_s),
        .grant     (pick_s),
        .any_valid (any_valid_s)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic [GRANT_W-1:0] rr_ptr_r;

    // Round-robin pointer: advance past the channel just granted, wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= {GRANT_W{1'b0}};
        end else if ((state_r == IDLE) && any_valid_s) begin
            rr_ptr_r <= (pick_s == GRANT_W'(NUM_CH - 1)) ? {GRANT_W{1'b0}}
                                                         : pick_s + GRANT_W'(1);
        end
    end

    assign rr_ptr_s = rr_ptr_r;
`else
    assign rr_ptr_s = {GRANT_W{1'b0}};
`endif

    // A channel raising both read and write is served as a write.
    always_comb begin
        if (ch_write[pick_s]) begin
            win_op_s = OP_WRITE;
        end else begin
            win_op_s = OP_READ;
        end
    end

    // Next-state logic; DONE never samples requests so the served channel
    // has one cycle to drop its request before the next arbitration.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (pmem_resp) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Completion is steered combinationally to the granted channel only while
    // a transaction is outstanding; stray pmem_resp elsewhere is ignored.
    always_comb begin
        ch_resp = {NUM_CH{1'b0}};
        if ((state_r == BUSY) && pmem_resp) begin
            ch_resp[grant_r] = 1'b1;
        end else begin
            ch_resp = {NUM_CH{1'b0}};
        end
    end

    assign ch_rdata = pmem_rdata;

    // State register plus request latches; pmem_* hold their values for the
    // whole transaction regardless of later ch_* activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            grant_r    <= {GRANT_W{1'b0}};
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= {ADDR_W{1'b0}};
            pmem_wdata <= {LINE_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (any_valid_s) begin
                        grant_r    <= pick_s;
                        pmem_read  <= (win_op_s == OP_READ);
                        pmem_write <= (win_op_s == OP_WRITE);
                        pmem_addr  <= ch_addr[pick_s];
                        pmem_wdata <= ch_wdata[pick_s];
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_n
// Self-checking bench for mem_arbiter_n (4 channels). A transaction-level
// reference (one request in flight, one idle gap after completion, winner by
// scan order) predicts pmem_* and ch_resp every cycle; directed scenarios add
// literal expectations for latency, grant order, latching and reset.
// ---------------------------------------------------------------------------
module tb_mem_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 256;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N-1:0]          ch_read  = '0;
    logic [N-1:0]          ch_write = '0;
    logic [N-1:0][AW-1:0]  ch_addr  = '0;
    logic [N-1:0][LW-1:0]  ch_wdata = '0;
    logic [N-1:0]          ch_resp;
    logic [LW-1:0]         ch_rdata;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [AW-1:0]         pmem_addr;
    logic [LW-1:0]         pmem_wdata;
    logic [LW-1:0]         pmem_rdata = '0;
    logic                  pmem_resp  = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_n #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_read    (ch_read),
        .ch_write   (ch_write),
        .ch_addr    (ch_addr),
        .ch_wdata   (ch_wdata),
        .ch_resp    (ch_resp),
        .ch_rdata   (ch_rdata),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    int checks   = 0;
    int failures = 0;

    // memory responder / channel agents
    int          lat        = 4;
    int          cnt        = 0;
    bit          auto_resp  = 1'b0;
    bit          force_resp = 1'b0;
    logic [31:0] rd_word    = 32'hA5A5_0000;
    logic [N-1:0] resp_last    = '0;
    logic [N-1:0] dropped_prev = '0;
    bit          rereq      = 1'b0;
    int          served_q[$];

    // reference model state
    bit            model_ok   = 1'b0;
    bit            m_inflight = 1'b0;
    bit            m_gap      = 1'b0;
    int            m_rr       = 0;
    int            m_g        = 0;
    logic          e_rd       = 1'b0;
    logic          e_wr       = 1'b0;
    logic [AW-1:0] e_addr     = '0;
    logic [LW-1:0] e_wdata    = '0;

    // Reference: one outstanding transaction, a one-cycle gap after it, and a
    // winner chosen by scanning from m_rr (always 0 for fixed priority).
    always @(posedge clk) begin : model
        int sel;
        if (rst) begin
            m_inflight = 1'b0;
            m_gap      = 1'b0;
            m_rr       = 0;
            m_g        = 0;
            e_rd       = 1'b0;
            e_wr       = 1'b0;
            e_addr     = '0;
            e_wdata    = '0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_inflight) begin
            if (pmem_resp) begin
                m_inflight = 1'b0;
                m_gap      = 1'b1;
                e_rd       = 1'b0;
                e_wr       = 1'b0;
            end
        end else begin
            sel = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (sel < 0 && (ch_read[idx] || ch_write[idx])) sel = idx;
            end
            if (sel >= 0) begin
                m_g        = sel;
                m_inflight = 1'b1;
                e_wr       = ch_write[sel];
                e_rd       = !ch_write[sel];
                e_addr     = ch_addr[sel];
                e_wdata    = ch_wdata[sel];
`ifdef ARB_ROUND_ROBIN_EN
                m_rr = (sel + 1) % N;
`endif
            end
        end
        model_ok = 1'b1;
    end

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive responder/agents after posedge, compare at negedge.
    task automatic step();
        logic [N-1:0] one;
        logic [N-1:0] exp_resp;
        one = 1;
        @(posedge clk);
        #2;
        if (auto_resp) begin
            auto_resp = 1'b0;
        end else if ((pmem_read || pmem_write) && !rst) begin
            cnt++;
            if (cnt >= lat) begin
                auto_resp  = 1'b1;
                cnt        = 0;
                pmem_rdata = {8{rd_word}};
                rd_word    = rd_word + 32'd1;
            end
        end else begin
            cnt = 0;
        end
        pmem_resp = auto_resp | force_resp;
        for (int i = 0; i < N; i++) begin
            if (resp_last[i]) begin
                ch_read[i]      = 1'b0;
                ch_write[i]     = 1'b0;
                dropped_prev[i] = 1'b1;
            end else if (dropped_prev[i]) begin
                dropped_prev[i] = 1'b0;
                if (rereq) ch_read[i] = 1'b1;
            end
        end
        @(negedge clk);
        resp_last = ch_resp;
        if (model_ok) begin
            exp_resp = (m_inflight && pmem_resp) ? (one << m_g) : '0;
            chk("pmem_read",  LW'(pmem_read),  LW'(e_rd));
            chk("pmem_write", LW'(pmem_write), LW'(e_wr));
            chk("pmem_addr",  LW'(pmem_addr),  LW'(e_addr));
            chk("pmem_wdata", pmem_wdata, e_wdata);
            chk("ch_resp",    LW'(ch_resp),    LW'(exp_resp));
            chk("ch_rdata",   ch_rdata, pmem_rdata);
        end
        for (int i = 0; i < N; i++) if (ch_resp[i]) served_q.push_back(i);
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int n = 0;
        while (served_q.size() < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (served_q.size() < target) begin
            failures++;
            $display("FAIL %s_timeout served=%0d required=%0d", name, served_q.size(), target);
        end
    endtask

    initial begin
        int base;
        int exp2 [2];
        int exp3 [5];
        int n;
`ifdef ARB_ROUND_ROBIN_EN
        exp2 = '{1, 0};
        exp3 = '{0, 1, 2, 3, 0};
`else
        exp2 = '{0, 1};
        exp3 = '{0, 0, 0, 0, 0};
`endif
        // reset state
        step(); step(); step();
        chk("rst_ch_resp", LW'(ch_resp), LW'(4'b0000));
        chk("rst_pmem_read", LW'(pmem_read), LW'(1'b0));
        chk("rst_pmem_addr", LW'(pmem_addr), LW'(32'h0));
        rst = 1'b0;
        step();

        // 1: single read ch0, memory latency 4
        ch_read[0] = 1'b1;
        ch_addr[0] = 32'h0000_1000;
        chk("t1_pre_read", LW'(pmem_read), LW'(1'b0));
        step();
        chk("t1_read_c1", LW'(pmem_read), LW'(1'b1));
        chk("t1_addr", LW'(pmem_addr), LW'(32'h0000_1000));
        step(); step(); step();
        chk("t1_resp", LW'(ch_resp), LW'(4'b0001));
        chk("t1_rdata", ch_rdata, {8{32'hA5A5_0000}});
        step();
        chk("t1_resp_drop", LW'(ch_resp), LW'(4'b0000));
        chk("t1_strobe_drop", LW'(pmem_read), LW'(1'b0));
        step(); step();

        // 2: ch0 read and ch1 write in the same cycle
        base = served_q.size();
        ch_read[0]  = 1'b1;
        ch_addr[0]  = 32'h0000_1100;
        ch_write[1] = 1'b1;
        ch_addr[1]  = 32'h0000_2040;
        ch_wdata[1] = {8{32'h0BAD_F00D}};
        run_until(base + 2, 60, "t2");
        for (int i = 0; i < 10; i++) step();
        chk("t2_count", LW'(served_q.size()), LW'(base + 2));
        if (served_q.size() >= base + 2) begin
            chk("t2_first", LW'(served_q[base]), LW'(exp2[0]));
            chk("t2_second", LW'(served_q[base + 1]), LW'(exp2[1]));
        end

        // 4: ch2 read+write (served as write), ch_* changed while busy
        base = served_q.size();
        ch_read[2]  = 1'b1;
        ch_write[2] = 1'b1;
        ch_addr[2]  = 32'h0000_3000;
        ch_wdata[2] = {8{32'h1357_9BDF}};
        step();
        chk("t4_write", LW'(pmem_write), LW'(1'b1));
        chk("t4_no_read", LW'(pmem_read), LW'(1'b0));
        ch_addr[2]  = 32'hDEAD_0000;
        ch_wdata[2] = {8{32'hFFFF_0000}};
        step();
        chk("t4_addr_hold", LW'(pmem_addr), LW'(32'h0000_3000));
        chk("t4_wdata_hold", pmem_wdata, {8{32'h1357_9BDF}});
        run_until(base + 1, 30, "t4");
        step(); step(); step();

        // 5: reset while BUSY, then a stray response
        lat = 20;
        ch_read[1] = 1'b1;
        ch_addr[1] = 32'h0000_4000;
        step(); step();
        chk("t5_busy", LW'(pmem_read), LW'(1'b1));
        rst = 1'b1;
        ch_read[1] = 1'b0;
        step();
        chk("t5_strobe_off", LW'(pmem_read), LW'(1'b0));
        rst = 1'b0;
        force_resp = 1'b1;
        step();
        chk("t5_no_resp", LW'(ch_resp), LW'(4'b0000));
        force_resp = 1'b0;
        step();
        chk("t5_idle", LW'(pmem_read | pmem_write), LW'(1'b0));
        lat = 4;

        // 6: spurious response while IDLE, arbiter still accepts a request
        force_resp = 1'b1;
        step();
        chk("t6_no_resp", LW'(ch_resp), LW'(4'b0000));
        force_resp = 1'b0;
        step();
        chk("t6_no_strobe", LW'(pmem_read | pmem_write), LW'(1'b0));
        base = served_q.size();
        ch_read[3] = 1'b1;
        ch_addr[3] = 32'h0000_5000;
        step();
        chk("t6_read_next", LW'(pmem_read), LW'(1'b1));
        run_until(base + 1, 30, "t6");
        step(); step();

        // 3: all four channels continuously requesting, from reset
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            ch_addr[i]  = 32'h0001_0000 + AW'(i * 64);
            ch_wdata[i] = {8{32'h0 + 32'(i)}};
        end
        rereq   = 1'b1;
        ch_read = 4'b1111;
        base    = served_q.size();
        run_until(base + 5, 200, "t3");
        if (served_q.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("t3_grant%0d", i), LW'(served_q[base + i]), LW'(exp3[i]));
        end
        rereq = 1'b0;
        n = 0;
        while (((ch_read | ch_write) != '0) && n < 300) begin
            step();
            n++;
        end
        chk("t3_drained", LW'(ch_read | ch_write), LW'(4'b0000));
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
